// File: rtl/line_memory_responder.sv
// Cache-line memory responder: serves one 256-bit line read or write at a time.
// Each request is acknowledged with a single-cycle pulse a fixed LATENCY after it is accepted.
module line_memory_responder #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LINES  = 512,
    parameter int LATENCY    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_enable_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_ack_o,
    output logic [DATA_WIDTH-1:0] mem_data_o
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  commit;

    logic [DATA_WIDTH-1:0] mem_q [MEM_LINES];

    // Offset bits and address bits above the array size do not select a line.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[ADDR_WIDTH-1:5+IDX_W], mem_addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_enable_i) begin
                    // The counter is loaded with LATENCY-1 so that the ACK entry edge lands
                    // exactly LATENCY edges after acceptance; this also covers LATENCY=1.
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = mem_addr_i[5 +: IDX_W];
                    wr_d    = mem_write_i;
                    wdata_d = mem_data_i;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    commit  = 1'b1;
                    if (!wr_q) rdata_d = mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Line storage survives reset; a write that coincides with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q && !rst_i) mem_q[idx_q] <= wdata_q;
    end

    assign mem_ack_o  = ack_q;
    assign mem_data_o = rdata_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Scoreboard bench for line_memory_responder: dut0 runs with LATENCY=10, dut1 with LATENCY=1.
module tb_line_memory_responder;
    localparam int DW = 256;
    localparam int AW = 32;
    localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] PAT_C3 = {32{8'hC3}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en0, wr0, ack0, en1, wr1, ack1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, din1, dout1;

    line_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LINES(512), .LATENCY(10)) dut0 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en0), .mem_write_i(wr0), .mem_addr_i(addr0),
        .mem_data_i(din0), .mem_ack_o(ack0), .mem_data_o(dout0));

    line_memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LINES(512), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en1), .mem_write_i(wr1), .mem_addr_i(addr1),
        .mem_data_i(din1), .mem_ack_o(ack1), .mem_data_o(dout1));

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd [2];

    task automatic drive(input bit sel, input bit en, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (sel) begin en1 = en; wr1 = wr; addr1 = a; din1 = d; end
        else     begin en0 = en; wr0 = wr; addr0 = a; din0 = d; end
    endtask

    // Issues one request and records the ack pulses seen in a bounded window.
    // c counts edges after the accepting edge; ack is expected at c == latency.
    task automatic issue(input bit sel, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit hold, input int mut_at, input int rst_at,
                         output int acks, output int ack_cyc, output logic [DW-1:0] ack_data);
        int lat;
        lat = sel ? 1 : 10;
        acks = 0; ack_cyc = -1; ack_data = '0;
        @(negedge clk);
        drive(sel, 1'b1, wr, a, d);
        @(posedge clk);
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) drive(sel, 1'b0, wr, a, d);
            if (mut_at >= 0 && c == mut_at) drive(sel, 1'b1, 1'b1, 32'h40, ~d);
            if (mut_at >= 0 && c == mut_at + 2) drive(sel, 1'b0, wr, a, d);
            if (rst_at >= 0 && c == rst_at) begin rst = 1'b1; drive(sel, 1'b0, wr, a, d); end
            if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
            if (sel ? ack1 : ack0) begin
                acks++;
                if (ack_cyc < 0) begin ack_cyc = c; ack_data = sel ? dout1 : dout0; end
            end
            if (hold && c == lat + 1) drive(sel, 1'b0, wr, a, d);
        end
    endtask

    task automatic test_reset;
        int acks;
        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL reset_ack0 got %0b want 0", ack0); end
        n_cmp++; if (dout0 !== '0) begin n_err++; $display("FAIL reset_data0 got %0h want 0", dout0); end
        n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL reset_ack1 got %0b want 0", ack1); end
        n_cmp++; if (dout1 !== '0) begin n_err++; $display("FAIL reset_data1 got %0h want 0", dout1); end
        // Enable together with reset must not start a request.
        drive(0, 1, 0, 32'h60, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, '0, '0);
        acks = 0;
        repeat (14) begin @(negedge clk); if (ack0) acks++; end
        n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL reset_vs_enable acks got %0d want 0", acks); end
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic test_read_basic;
        int acks, cyc;
        logic [DW-1:0] d, got;
        issue(0, 1, 32'h60, PAT_A5, 0, -1, -1, acks, cyc, d);
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL preload_lat got %0d want 10", cyc); end
        exp_q.push_back(PAT_A5);
        issue(0, 0, 32'h60, '0, 0, -1, -1, acks, cyc, d);
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL read_lat got %0d want 10", cyc); end
        n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL read_acks got %0d want 1", acks); end
        got = exp_q.pop_front();
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL read_data got %0h want %0h", d, got); end
        last_rd[0] = got;
        repeat (5) @(negedge clk);
        n_cmp++; if (dout0 !== got) begin n_err++; $display("FAIL read_hold got %0h want %0h", dout0, got); end
    endtask

    task automatic test_write_read;
        int acks, cyc;
        logic [DW-1:0] d, got;
        issue(0, 1, 32'h80, 256'h1234, 0, -1, -1, acks, cyc, d);
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL wr_lat got %0d want 10", cyc); end
        n_cmp++; if (d !== last_rd[0]) begin n_err++; $display("FAIL wr_data_o got %0h want %0h", d, last_rd[0]); end
        exp_q.push_back(256'h1234);
        issue(0, 0, 32'h80, '0, 0, -1, -1, acks, cyc, d);
        got = exp_q.pop_front();
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL wr_rd_lat got %0d want 10", cyc); end
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL wr_rd_data got %0h want %0h", d, got); end
        last_rd[0] = got;
    endtask

    task automatic test_hold_enable;
        int acks, cyc, extra;
        logic [DW-1:0] d, got;
        exp_q.push_back(PAT_A5);
        issue(0, 0, 32'h60, '0, 1, -1, -1, acks, cyc, d);
        got = exp_q.pop_front();
        n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL hold_acks got %0d want 1", acks); end
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL hold_data got %0h want %0h", d, got); end
        last_rd[0] = got;
        extra = 0;
        repeat (14) begin @(negedge clk); if (ack0) extra++; end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL hold_extra_ack got %0d want 0", extra); end
    endtask

    task automatic test_midreq_change;
        int acks, cyc;
        logic [DW-1:0] d, got;
        issue(0, 1, 32'h40, PAT_C3, 0, -1, -1, acks, cyc, d);
        n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL mid_preload_acks got %0d want 1", acks); end
        exp_q.push_back(PAT_A5);
        issue(0, 0, 32'h60, '0, 0, 3, -1, acks, cyc, d);
        got = exp_q.pop_front();
        n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL mid_lat got %0d want 10", cyc); end
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL mid_data got %0h want %0h", d, got); end
        exp_q.push_back(PAT_C3);
        issue(0, 0, 32'h40, '0, 0, -1, -1, acks, cyc, d);
        got = exp_q.pop_front();
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL mid_line2 got %0h want %0h", d, got); end
        last_rd[0] = got;
    endtask

    task automatic test_reset_mid;
        int acks, cyc;
        logic [DW-1:0] d, got;
        issue(0, 1, 32'hE0, 256'hDEAD_BEEF, 0, -1, -1, acks, cyc, d);
        issue(0, 1, 32'hE0, 256'h0BAD_F00D, 0, -1, 4, acks, cyc, d);
        last_rd[0] = '0;
        last_rd[1] = '0;
        n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL rstmid_acks got %0d want 0", acks); end
        n_cmp++; if (dout0 !== '0) begin n_err++; $display("FAIL rstmid_data_o got %0h want 0", dout0); end
        exp_q.push_back(256'hDEAD_BEEF);
        issue(0, 0, 32'hE0, '0, 0, -1, -1, acks, cyc, d);
        got = exp_q.pop_front();
        n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL rstmid_rd_acks got %0d want 1", acks); end
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL rstmid_line7 got %0h want %0h", d, got); end
        last_rd[0] = got;
    endtask

    task automatic test_latency1_wrap;
        int acks, cyc;
        logic [DW-1:0] d, got;
        issue(1, 1, 32'h3FE0, 256'h5151, 0, -1, -1, acks, cyc, d);
        n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL l1_wr_lat got %0d want 1", cyc); end
        n_cmp++; if (d !== last_rd[1]) begin n_err++; $display("FAIL l1_wr_data_o got %0h want %0h", d, last_rd[1]); end
        exp_q.push_back(256'h5151);
        issue(1, 0, 32'h7FE0, '0, 0, -1, -1, acks, cyc, d);
        got = exp_q.pop_front();
        n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL l1_rd_lat got %0d want 1", cyc); end
        n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL l1_rd_acks got %0d want 1", acks); end
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL l1_wrap_a got %0h want %0h", d, got); end
        issue(1, 1, 32'h7FE0, 256'h7E7E, 0, -1, -1, acks, cyc, d);
        exp_q.push_back(256'h7E7E);
        issue(1, 0, 32'h3FE0, '0, 0, -1, -1, acks, cyc, d);
        got = exp_q.pop_front();
        n_cmp++; if (d !== got) begin n_err++; $display("FAIL l1_wrap_b got %0h want %0h", d, got); end
        last_rd[1] = got;
    endtask

    task automatic test_back_to_back;
        int acks, cyc;
        logic [DW-1:0] d, got, v;
        logic [DW-1:0] wv [4];
        for (int i = 0; i < 4; i++) begin
            wv[i] = {8{$urandom()}};
            issue(1, 1, 32'(i * 32 + 32'h1000), wv[i], 0, -1, -1, acks, cyc, d);
        end
        for (int i = 3; i >= 0; i--) begin
            v = wv[i];
            exp_q.push_back(v);
            issue(1, 0, 32'(i * 32 + 32'h1000), '0, 0, -1, -1, acks, cyc, d);
            got = exp_q.pop_front();
            n_cmp++; if (d !== got) begin n_err++; $display("FAIL b2b_line%0d got %0h want %0h", i, d, got); end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_read();
        test_hold_enable();
        test_midreq_change();
        test_reset_mid();
        test_latency1_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
